// File: rtl/bus_target_if.sv
// CPU-side bus of bus_target: address, write strobe, write data and registered read data.
interface bus_target_if;
  logic [15:0] Address;
  logic        WE;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;

  modport master (output Address, output WE, output DataIn, input DataOut);
  modport slave  (input Address, input WE, input DataIn, output DataOut);
endinterface

// File: rtl/bus_target.sv
// CPU bus target: 2 KB RAM plus an I/O page holding a GPIO port, a reloadable
// 16-bit down-counter timer with interrupt, and a 4-entry show-ahead TX FIFO.
module bus_target #(
  parameter int unsigned RAM_AW  = 11,
  parameter logic [7:0]  IO_PAGE = 8'hD0
) (
  input  logic         CLK,
  input  logic         R_N,
  bus_target_if.slave  bus,
  output logic [7:0]   PORT_OUT,
  output logic         IRQ,
  output logic [7:0]   TX_DATA,
  output logic         TX_VALID,
  input  logic         TX_READY
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [3:0] A_PORT  = 4'h0;
  localparam logic [3:0] A_TRLO  = 4'h1;
  localparam logic [3:0] A_TRHI  = 4'h2;
  localparam logic [3:0] A_TCTL  = 4'h3;
  localparam logic [3:0] A_TSTAT = 4'h4;
  localparam logic [3:0] A_FIFO  = 4'h5;
  localparam logic [3:0] A_FSTAT = 4'h6;

  logic [7:0]        ram_mem [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram, is_io, wr_io;
  logic [3:0]        reg_sel;

  logic [7:0]  dout_q, dout_d, port_q, port_d, trlo_q, trlo_d, trhi_q, trhi_d;
  logic        en_q, en_d, auto_q, auto_d, irqen_q, irqen_d, exp_q, exp_d, ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;

  logic        empty, full, pop, push_req, push_ok;
  logic [7:0]  head, fstat, rdata;

  assign ram_idx = bus.Address[RAM_AW-1:0];
  assign is_ram  = (bus.Address >> RAM_AW) == 16'd0;
  assign is_io   = !is_ram && (bus.Address[15:8] == IO_PAGE);
  assign reg_sel = bus.Address[3:0];
  assign wr_io   = bus.WE && is_io;

  assign empty    = (count_q == 3'd0);
  assign full     = (count_q == 3'd4);
  assign head     = fifo_q[rd_ptr_q];
  assign pop      = !empty && TX_READY;
  assign push_req = wr_io && (reg_sel == A_FIFO);
  assign push_ok  = push_req && (!full || pop);
  assign fstat    = {2'b00, ovf_q, count_q, full, empty};

  always_comb begin
    rdata = 8'hFF;
    if (is_ram) begin
      rdata = ram_mem[ram_idx];
    end else if (is_io) begin
      case (reg_sel)
        A_PORT:  rdata = port_q;
        A_TRLO:  rdata = trlo_q;
        A_TRHI:  rdata = trhi_q;
        A_TCTL:  rdata = {5'b00000, irqen_q, auto_q, en_q};
        A_TSTAT: rdata = {7'b0000000, exp_q};
        A_FIFO:  rdata = empty ? 8'hFF : head;
        A_FSTAT: rdata = fstat;
        default: rdata = 8'hFF;
      endcase
    end
  end

  always_comb begin
    dout_d   = rdata;
    port_d   = port_q;
    trlo_d   = trlo_q;
    trhi_d   = trhi_q;
    en_d     = en_q;
    auto_d   = auto_q;
    irqen_d  = irqen_q;
    exp_d    = exp_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (en_q) begin
      if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
      else if (auto_q)    cnt_d = {trhi_q, trlo_q};
      else                en_d  = 1'b0;
    end

    // Clear is applied first so a coincident expiry still leaves EXP set.
    if (wr_io && (reg_sel == A_TSTAT) && bus.DataIn[0]) exp_d = 1'b0;
    if (en_q && (cnt_q == 16'd0)) exp_d = 1'b1;

    if (wr_io) begin
      case (reg_sel)
        A_PORT:  port_d = bus.DataIn;
        A_TRLO:  trlo_d = bus.DataIn;
        A_TRHI: begin
          trhi_d = bus.DataIn;
          cnt_d  = {bus.DataIn, trlo_q};
          en_d   = 1'b1;
        end
        A_TCTL:  {irqen_d, auto_d, en_d} = bus.DataIn[2:0];
        A_FSTAT: if (bus.DataIn[5]) ovf_d = 1'b0;
        default: ;
      endcase
    end

    if (push_req && full && !pop) ovf_d = 1'b1;

    // When full with a pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
    if (push_ok) begin
      fifo_d[wr_ptr_q] = bus.DataIn;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      dout_q   <= 8'h00;
      port_q   <= 8'h00;
      trlo_q   <= 8'h00;
      trhi_q   <= 8'h00;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irqen_q  <= 1'b0;
      exp_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 16'h0000;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
    end else begin
      dout_q   <= dout_d;
      port_q   <= port_d;
      trlo_q   <= trlo_d;
      trhi_q   <= trhi_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      irqen_q  <= irqen_d;
      exp_q    <= exp_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (bus.WE && is_ram) ram_mem[ram_idx] <= bus.DataIn;
  end

  assign bus.DataOut = dout_q;
  assign PORT_OUT    = port_q;
  assign IRQ         = exp_q & irqen_q;
  assign TX_VALID    = !empty;
  assign TX_DATA     = empty ? 8'h00 : head;

endmodule

// File: tb/tb_bus_target.sv
// Self-checking bench for bus_target: directed vector table, hand-written timer,
// FIFO and async-reset sequences, then random traffic against a queue-based model.
module tb_bus_target;

  logic       CLK;
  logic       R_N;
  logic [7:0] PORT_OUT;
  logic       IRQ;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  bus_target_if bus ();

  bus_target dut (
    .CLK      (CLK),
    .R_N      (R_N),
    .bus      (bus),
    .PORT_OUT (PORT_OUT),
    .IRQ      (IRQ),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_ram [0:2047];
  bit         m_known [0:2047];
  logic [7:0] m_port, m_trlo, m_trhi;
  bit         m_en, m_auto, m_irqen, m_exp, m_ovf;
  int         m_cnt;
  logic [7:0] m_fifo [$];
  logic [7:0] e_dout;
  bit         e_dknown;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  din;
    logic        txr;
    logic        chk_dout;
    logic [7:0]  dout;
    logic [7:0]  port;
    logic        irq;
    logic        txv;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_port = 8'h00; m_trlo = 8'h00; m_trhi = 8'h00;
    m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_ovf = 0;
    m_cnt = 0;
    m_fifo.delete();
  endtask

  task automatic model_step(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r);
    bit io, expire;
    int sel, n;
    io = (a >= 16'h0800) && (a[15:8] == 8'hD0);
    sel = int'(a[3:0]);
    n = m_fifo.size();
    e_dknown = 1;
    e_dout = 8'hFF;
    if (a < 16'h0800) begin
      e_dknown = m_known[a[10:0]];
      e_dout = m_ram[a[10:0]];
    end else if (io) begin
      case (sel)
        0: e_dout = m_port;
        1: e_dout = m_trlo;
        2: e_dout = m_trhi;
        3: e_dout = {5'd0, m_irqen, m_auto, m_en};
        4: e_dout = {7'd0, m_exp};
        5: e_dout = (n == 0) ? 8'hFF : m_fifo[0];
        6: e_dout = {2'd0, m_ovf, 3'(n), n == 4, n == 0};
        default: e_dknown = 0;
      endcase
    end

    expire = m_en && (m_cnt == 0);
    if (m_en) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (m_auto) m_cnt = int'(m_trhi) * 256 + int'(m_trlo);
      else m_en = 0;
    end
    if (expire) m_exp = 1;
    else if (w && io && sel == 4 && d[0]) m_exp = 0;

    if (n != 0 && r) void'(m_fifo.pop_front());
    if (w && io && sel == 6 && d[5]) m_ovf = 0;
    if (w && io && sel == 5) begin
      if (m_fifo.size() < 4) m_fifo.push_back(d);
      else m_ovf = 1;
    end

    if (w && io) begin
      case (sel)
        0: m_port = d;
        1: m_trlo = d;
        2: begin m_trhi = d; m_cnt = int'(d) * 256 + int'(m_trlo); m_en = 1; end
        3: begin m_en = d[0]; m_auto = d[1]; m_irqen = d[2]; end
        default: ;
      endcase
    end
    if (w && a < 16'h0800) begin
      m_ram[a[10:0]] = d;
      m_known[a[10:0]] = 1;
    end
  endtask

  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r);
    bus.Address = a;
    bus.WE      = w;
    bus.DataIn  = d;
    TX_READY    = r;
    model_step(a, w, d, r);
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r,
                     input logic c, input logic [7:0] dout, input logic [7:0] port,
                     input logic irq, input logic txv, input logic [7:0] txd);
    vec_t v;
    v = '{a, w, d, r, c, dout, port, irq, txv, txd};
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1: return 16'h0000 + 16'($urandom_range(0, 15));
      2:    return 16'h07F0 + 16'($urandom_range(0, 15));
      3: begin
        case ($urandom_range(0, 4))
          0: return 16'h0800;
          1: return 16'h1234;
          2: return 16'hFFFF;
          3: return 16'hD100;
          default: return 16'hCF05;
        endcase
      end
      default: return 16'hD000 + 16'($urandom_range(0, 6));
    endcase
  endfunction

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;

    R_N = 1'b0;
    bus.Address = 16'h0000;
    bus.WE = 1'b0;
    bus.DataIn = 8'h00;
    TX_READY = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dout", bus.DataOut, 8'h00);
    chk("rst_port", PORT_OUT, 8'h00);
    chk("rst_irq", IRQ, 1'b0);
    chk("rst_txv", TX_VALID, 1'b0);
    chk("rst_txd", TX_DATA, 8'h00);
    @(negedge CLK);
    R_N = 1'b1;

    //  addr     we    din    txr   chk   dout   port   irq   txv   txd
    add(16'h0123, 1, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add(16'h0123, 0, 8'h00, 0, 1, 8'h5A, 8'h00, 0, 0, 8'h00);
    add(16'h1234, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(16'h0800, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(16'h0123, 1, 8'hA5, 0, 1, 8'h5A, 8'h00, 0, 0, 8'h00);
    add(16'h0123, 0, 8'h00, 0, 1, 8'hA5, 8'h00, 0, 0, 8'h00);
    add(16'hD000, 1, 8'h3C, 0, 1, 8'h00, 8'h3C, 0, 0, 8'h00);
    add(16'hD000, 0, 8'h00, 0, 1, 8'h3C, 8'h3C, 0, 0, 8'h00);
    add(16'h1234, 1, 8'h77, 0, 1, 8'hFF, 8'h3C, 0, 0, 8'h00);
    add(16'hD004, 0, 8'h00, 0, 1, 8'h00, 8'h3C, 0, 0, 8'h00);
    add(16'hD005, 1, 8'h11, 0, 1, 8'hFF, 8'h3C, 0, 1, 8'h11);
    add(16'hD005, 1, 8'h22, 0, 1, 8'h11, 8'h3C, 0, 1, 8'h11);
    add(16'hD005, 1, 8'h33, 0, 1, 8'h11, 8'h3C, 0, 1, 8'h11);
    add(16'hD005, 1, 8'h44, 0, 1, 8'h11, 8'h3C, 0, 1, 8'h11);
    add(16'hD005, 1, 8'h55, 0, 1, 8'h11, 8'h3C, 0, 1, 8'h11);
    add(16'hD006, 0, 8'h00, 0, 1, 8'h32, 8'h3C, 0, 1, 8'h11);
    add(16'hD005, 0, 8'h00, 1, 1, 8'h11, 8'h3C, 0, 1, 8'h22);
    add(16'hD006, 0, 8'h00, 1, 1, 8'h2C, 8'h3C, 0, 1, 8'h33);
    add(16'hD000, 0, 8'h00, 1, 1, 8'h3C, 8'h3C, 0, 1, 8'h44);
    add(16'hD000, 0, 8'h00, 1, 1, 8'h3C, 8'h3C, 0, 0, 8'h00);
    add(16'hD006, 0, 8'h00, 0, 1, 8'h21, 8'h3C, 0, 0, 8'h00);
    add(16'hD006, 1, 8'h20, 0, 1, 8'h21, 8'h3C, 0, 0, 8'h00);
    add(16'hD006, 0, 8'h00, 0, 1, 8'h01, 8'h3C, 0, 0, 8'h00);

    foreach (tbl[i]) begin
      cyc(tbl[i].addr, tbl[i].we, tbl[i].din, tbl[i].txr);
      if (tbl[i].chk_dout) chk($sformatf("vec%0d_dout", i), bus.DataOut, tbl[i].dout);
      chk($sformatf("vec%0d_port", i), PORT_OUT, tbl[i].port);
      chk($sformatf("vec%0d_irq", i), IRQ, tbl[i].irq);
      chk($sformatf("vec%0d_txv", i), TX_VALID, tbl[i].txv);
      chk($sformatf("vec%0d_txd", i), TX_DATA, tbl[i].txd);
    end

    // Auto-reload timer with interrupt, period 4
    cyc(16'hD001, 1, 8'h03, 0);
    cyc(16'hD003, 1, 8'h06, 0);
    cyc(16'hD002, 1, 8'h00, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(16'hD000, 0, 8'h00, 0);
      chk($sformatf("tmr_pre_irq%0d", i), IRQ, 1'b0);
    end
    cyc(16'hD000, 0, 8'h00, 0);
    chk("tmr_exp_irq", IRQ, 1'b1);
    cyc(16'hD004, 1, 8'h01, 0);
    chk("tmr_clr_irq", IRQ, 1'b0);
    cyc(16'hD000, 0, 8'h00, 0);
    chk("tmr_reload_irq6", IRQ, 1'b0);
    cyc(16'hD000, 0, 8'h00, 0);
    chk("tmr_reload_irq7", IRQ, 1'b0);
    cyc(16'hD004, 1, 8'h01, 0);
    chk("tmr_set_beats_clr", IRQ, 1'b1);
    cyc(16'hD004, 0, 8'h00, 0);
    chk("tmr_tstat_rd", bus.DataOut, 8'h01);
    cyc(16'hD003, 1, 8'h00, 0);
    chk("tmr_irqen_off", IRQ, 1'b0);
    cyc(16'hD004, 1, 8'h01, 0);
    cyc(16'hD004, 0, 8'h00, 0);
    chk("tmr_tstat_clr", bus.DataOut, 8'h00);

    // One-shot timer
    cyc(16'hD001, 1, 8'h01, 0);
    cyc(16'hD002, 1, 8'h00, 0);
    cyc(16'hD004, 0, 8'h00, 0);
    chk("os_exp_c1", bus.DataOut, 8'h00);
    cyc(16'hD004, 0, 8'h00, 0);
    chk("os_exp_c2", bus.DataOut, 8'h00);
    cyc(16'hD004, 0, 8'h00, 0);
    chk("os_exp_set", bus.DataOut, 8'h01);
    cyc(16'hD003, 0, 8'h00, 0);
    chk("os_tctl", bus.DataOut, 8'h00);
    chk("os_irq", IRQ, 1'b0);
    cyc(16'hD004, 1, 8'h01, 0);

    // Full FIFO with simultaneous push and pop
    cyc(16'hD005, 1, 8'hA1, 0);
    cyc(16'hD005, 1, 8'hA2, 0);
    cyc(16'hD005, 1, 8'hA3, 0);
    cyc(16'hD005, 1, 8'hA4, 0);
    cyc(16'hD005, 1, 8'hA5, 1);
    chk("pp_txd", TX_DATA, 8'hA2);
    cyc(16'hD006, 0, 8'h00, 0);
    chk("pp_fstat", bus.DataOut, 8'h12);
    cyc(16'hD000, 0, 8'h00, 1);
    chk("pp_drain1", TX_DATA, 8'hA3);
    cyc(16'hD000, 0, 8'h00, 1);
    chk("pp_drain2", TX_DATA, 8'hA4);
    cyc(16'hD000, 0, 8'h00, 1);
    chk("pp_drain3", TX_DATA, 8'hA5);
    cyc(16'hD000, 0, 8'h00, 1);
    chk("pp_empty", TX_VALID, 1'b0);

    // Asynchronous reset while timer runs and FIFO holds data
    cyc(16'hD001, 1, 8'h00, 0);
    cyc(16'hD003, 1, 8'h06, 0);
    cyc(16'hD002, 1, 8'h00, 0);
    cyc(16'hD005, 1, 8'h66, 0);
    chk("ar_pre_irq", IRQ, 1'b1);
    chk("ar_pre_txv", TX_VALID, 1'b1);
    chk("ar_pre_port", PORT_OUT, 8'h3C);
    bus.WE = 1'b0;
    TX_READY = 1'b0;
    #3;
    R_N = 1'b0;
    m_reset();
    #1;
    chk("ar_irq", IRQ, 1'b0);
    chk("ar_txv", TX_VALID, 1'b0);
    chk("ar_txd", TX_DATA, 8'h00);
    chk("ar_port", PORT_OUT, 8'h00);
    chk("ar_dout", bus.DataOut, 8'h00);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    R_N = 1'b1;
    cyc(16'hD006, 0, 8'h00, 0);
    chk("ar_fstat", bus.DataOut, 8'h01);
    cyc(16'hD003, 0, 8'h00, 0);
    chk("ar_tctl", bus.DataOut, 8'h00);
    cyc(16'hD000, 1, 8'h99, 0);
    chk("ar_port_wr", PORT_OUT, 8'h99);
    cyc(16'h0123, 0, 8'h00, 0);
    chk("ar_ram_kept", bus.DataOut, 8'hA5);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      a = rand_addr();
      w = ($urandom_range(0, 9) < 4);
      d = 8'($urandom);
      if (a == 16'hD002) d = 8'($urandom_range(0, 1));
      if (a == 16'hD001) d = 8'($urandom_range(0, 12));
      cyc(a, w, d, 1'($urandom_range(0, 1)));
      if (e_dknown) chk("rnd_dout", bus.DataOut, e_dout);
      chk("rnd_port", PORT_OUT, m_port);
      chk("rnd_irq", IRQ, m_exp & m_irqen);
      chk("rnd_txv", TX_VALID, m_fifo.size() != 0);
      chk("rnd_txd", TX_DATA, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_target.md
BUS_TARGET -- requirements
Module: bus_target

Interface
REQ-001 Parameter: RAM_AW, default 11, RAM address width (2 KB RAM at 0x0000-0x07FF).
REQ-002 Parameter: IO_PAGE, default 8'hD0, Address[15:8] value selecting the I/O page.
REQ-003 Port: CLK, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port: R_N, input, 1, reset; asynchronous, active-low.
REQ-005 Port: Address, input, 16, CPU bus address.
REQ-006 Port: WE, input, 1, write strobe; sampled at the rising edge of CLK.
REQ-007 Port: DataIn, input, 8, write data from the CPU.
REQ-008 Port: DataOut, output, 8, registered read data to the CPU.
REQ-009 Port: PORT_OUT, output, 8, general-purpose output register.
REQ-010 Port: IRQ, output, 1, timer interrupt, level, active-high.
REQ-011 Port: TX_DATA, output, 8, head entry of the FIFO.
REQ-012 Port: TX_VALID, output, 1, FIFO not empty.
REQ-013 Port: TX_READY, input, 1, consumer accepts the head entry when TX_VALID is also high.

Function
REQ-014 Decode regions:
- RAM: Address < 2^RAM_AW.
- I/O: Address[15:8]==IO_PAGE, register selected by Address[3:0].
- Anything else is unmapped.
REQ-015 Read timing: DataOut SHALL be updated every cycle from the Address sampled at that edge, giving one-cycle read latency.
REQ-016 Read-before-write: a same-cycle read and write to one location returns the old value; the next cycle returns the new value.
REQ-017 Writes take effect only when WE=1.
- Unmapped or read-only targets ignore writes.
- Unmapped reads return 8'hFF.
REQ-018 I/O map:
- 0x0 PORT (rw).
- 0x1 TRLO (rw), timer reload low byte.
- 0x2 TRHI (rw), timer reload high byte.
- 0x3 TCTL (rw): bit0 EN, bit1 AUTO, bit2 IRQEN.
- 0x4 TSTAT: bit0 EXP; write-1-to-clear.
- 0x5 FIFO data: a write pushes; a read returns the head, or 8'hFF when empty.
- 0x6 FSTAT: bit0 EMPTY, bit1 FULL, bits4:2 COUNT, bit5 OVF; writing 1 to bit5 clears OVF.
- Unused bits read 0.
REQ-019 Writing TRHI loads the 16-bit counter with {DataIn, TRLO} and sets EN=1 on the same edge.
REQ-020 Timer countdown, while EN=1:
- counter!=0: counter decrements by 1 each cycle.
- counter==0: EXP is set; if AUTO=1 the counter reloads {TRHI,TRLO}, otherwise EN clears.
- EN=0: the counter holds.
REQ-021 Simultaneous timer events: if expiry coincides with a TSTAT clear write, the set wins and EXP=1. A TCTL write in the expiry cycle overrides the EN/AUTO outcome.
REQ-022 IRQ SHALL equal EXP AND IRQEN, combinationally from registers.
REQ-023 FIFO: 4 entries, show-ahead.
- TX_VALID = not EMPTY.
- TX_DATA = head entry.
- A pop occurs when TX_VALID AND TX_READY.
REQ-024 FIFO push: a write to 0x5 pushes.
- If FULL with no pop in that cycle, the data is dropped and OVF is set (sticky).
- If FULL with a pop in the same cycle, the push is accepted and COUNT stays 4.
REQ-025 FIFO occupancy: simultaneous push and pop when not empty leaves COUNT unchanged. Pointers wrap modulo 4; COUNT ranges 0..4.
REQ-026 Reads have no side effects, including reads of 0x5 and 0x6.

Reset
REQ-027 While R_N=0, and immediately on its assertion:
- DataOut, PORT_OUT, TRLO, TRHI, TCTL, EXP, OVF, counter and FIFO pointers all = 0.
- IRQ=0, TX_VALID=0, TX_DATA=0.
REQ-028 RAM contents are not reset.
REQ-029 Reset asserted mid-operation discards the timer state and FIFO contents. The first access after R_N rises is serviced normally on the next CLK edge.

Verification
REQ-030 RAM: write 0x5A to 0x0123, then read 0x0123 -> DataOut=0x5A one cycle after the read address. Read 0x1234 -> 0xFF.
REQ-031 Timer: TRLO=0x03, TCTL=0x06, TRHI=0x00 -> EXP and IRQ rise 4 cycles after the TRHI write edge and reload to 3.
- Write 0x01 to TSTAT in the expiry cycle -> EXP stays 1.
REQ-032 One-shot timer: TCTL=0x00, TRLO=0x01, TRHI=0x00 -> EXP=1 after 2 cycles, then EN=0 and TCTL reads 0x00.
REQ-033 FIFO fill: with TX_READY=0, push 0x11,0x22,0x33,0x44,0x55 -> FSTAT=0x32 (FULL, COUNT=4, OVF=1) and TX_DATA=0x11. Then TX_READY=1 -> TX_DATA sequence 0x22,0x33,0x44, then EMPTY.
REQ-034 FIFO full with push and pop in the same cycle -> COUNT stays 4, no OVF, and the new byte appears last.
REQ-035 Reset: assert R_N=0 asynchronously, between edges, while the timer is running and the FIFO is non-empty -> IRQ, TX_VALID and PORT_OUT go to 0 without a clock edge.
